// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus: PC loop, program port, instruction register
// master = fetch stage, slave = PC / programmer / downstream consumer.
interface instr_fetch_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              if_start;
    logic [ADDR_W-1:0] if_pc;
    logic              if_zero;
    logic              if_jmp_enb;
    logic [ADDR_W-1:0] if_jmp_target;
    logic              if_prog_we;
    logic [ADDR_W-1:0] if_prog_addr;
    logic [DATA_W-1:0] if_prog_data;
    logic [DATA_W-1:0] if_instr;
    logic [ADDR_W-1:0] if_instr_addr;
    logic              if_instr_valid;
    logic              if_halted;

    modport master (
        input  if_start, if_pc, if_zero, if_prog_we, if_prog_addr, if_prog_data,
        output if_jmp_enb, if_jmp_target, if_instr, if_instr_addr, if_instr_valid, if_halted
    );

    modport slave (
        output if_start, if_pc, if_zero, if_prog_we, if_prog_addr, if_prog_data,
        input  if_jmp_enb, if_jmp_target, if_instr, if_instr_addr, if_instr_valid, if_halted
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage with jump/branch-on-zero/halt decode and PC feedback
// Optional retired-instruction counter enabled by IFETCH_PERF_EN.
module instr_fetch #(
    parameter int         ADDR_W = 4,
    parameter int         DATA_W = 8,
    parameter logic [3:0] OP_JMP = 4'hA,
    parameter logic [3:0] OP_JZ  = 4'hB,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic         if_clk,
    input  logic         if_rst,
    instr_fetch_if.master bus
`ifdef IFETCH_PERF_EN
    ,
    output logic [7:0]   if_retired_cnt
`endif
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_instr;
    logic [ADDR_W-1:0] r_instr_addr;
    logic [ADDR_W-1:0] r_halt_addr;
    logic              r_valid;
    logic              r_halted;

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic              w_run;
    logic              w_taken;
    logic              w_hlt_now;
    logic              w_jmp_enb;
    logic [ADDR_W-1:0] w_jmp_target;

    assign w_opcode  = r_instr[DATA_W-1 -: 4];
    assign w_operand = r_instr[ADDR_W-1:0];
    assign w_run     = (r_state == S_RUN);
    assign w_taken   = w_run & r_valid & ((w_opcode == OP_JMP) | ((w_opcode == OP_JZ) & bus.if_zero));
    assign w_hlt_now = w_run & r_valid & (w_opcode == OP_HLT);

    always_ff @(posedge if_clk) begin
        if (bus.if_prog_we) begin
            r_mem[bus.if_prog_addr] <= bus.if_prog_data;
        end
    end

    // PC load path: IDLE pins PC to 0, HALTED freezes it at the HLT address.
    always_comb begin
        w_jmp_enb    = 1'b0;
        w_jmp_target = '0;
        case (r_state)
            S_IDLE: begin
                w_jmp_enb    = 1'b1;
                w_jmp_target = '0;
            end
            S_RUN: begin
                if (w_hlt_now) begin
                    w_jmp_enb    = 1'b1;
                    w_jmp_target = r_instr_addr;
                end else if (w_taken) begin
                    w_jmp_enb    = 1'b1;
                    w_jmp_target = w_operand;
                end
            end
            S_HALTED: begin
                w_jmp_enb    = 1'b1;
                w_jmp_target = r_halt_addr;
            end
            default: begin
                w_jmp_enb    = 1'b1;
                w_jmp_target = '0;
            end
        endcase
    end

    always_ff @(posedge if_clk or posedge if_rst) begin
        if (if_rst) begin
            r_state      <= S_IDLE;
            r_instr      <= '0;
            r_instr_addr <= '0;
            r_halt_addr  <= '0;
            r_valid      <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.if_start) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_instr      <= r_mem[bus.if_pc];
                    r_instr_addr <= bus.if_pc;
                    // Fall-through word behind a taken jump or a halt is squashed.
                    r_valid      <= ~w_taken & ~w_hlt_now;
                    if (w_hlt_now) begin
                        r_halt_addr <= r_instr_addr;
                        r_halted    <= 1'b1;
                        r_state     <= S_HALTED;
                    end
                end
                S_HALTED: begin
                    r_valid <= 1'b0;
                    if (bus.if_start) begin
                        r_halted <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    logic [7:0] r_retired_cnt;

    always_ff @(posedge if_clk or posedge if_rst) begin
        if (if_rst) begin
            r_retired_cnt <= 8'd0;
        end else if ((r_state == S_IDLE) && bus.if_start) begin
            r_retired_cnt <= 8'd0;
        end else if (r_valid && (r_retired_cnt != 8'hFF)) begin
            r_retired_cnt <= r_retired_cnt + 8'd1;
        end
    end

    assign if_retired_cnt = r_retired_cnt;
`endif

    assign bus.if_jmp_enb     = w_jmp_enb;
    assign bus.if_jmp_target  = w_jmp_target;
    assign bus.if_instr       = r_instr;
    assign bus.if_instr_addr  = r_instr_addr;
    assign bus.if_instr_valid = r_valid;
    assign bus.if_halted      = r_halted;
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with a PC register closing the loop
module tb_instr_fetch;
    logic       clk;
    logic       rst;
    logic [3:0] pc;
    int         total;
    int         bad;
`ifdef IFETCH_PERF_EN
    logic [7:0] retired_cnt;
`endif

    instr_fetch_if #(.ADDR_W(4), .DATA_W(8)) bus ();

    instr_fetch #(.ADDR_W(4), .DATA_W(8)) dut (
        .if_clk (clk),
        .if_rst (rst),
        .bus    (bus)
`ifdef IFETCH_PERF_EN
        ,
        .if_retired_cnt (retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream program counter: loads on jmp_enb, otherwise increments.
    always @(posedge clk or posedge rst) begin
        if (rst)                 pc <= 4'd0;
        else if (bus.if_jmp_enb) pc <= bus.if_jmp_target;
        else                     pc <= pc + 4'd1;
    end
    assign bus.if_pc = pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic prog(input logic [3:0] a, input logic [7:0] d);
        bus.if_prog_we   = 1'b1;
        bus.if_prog_addr = a;
        bus.if_prog_data = d;
        tick();
        bus.if_prog_we   = 1'b0;
    endtask

    // Reset, then start; returns in the first RUN cycle (PC=0, IR not yet valid).
    task automatic begin_run();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        bus.if_start = 1'b1;
        tick();
        bus.if_start = 1'b0;
    endtask

    task automatic chk_ir(input string tag, input logic [7:0] d, input logic [3:0] a, input logic v);
        chk({tag, "_instr"}, {24'd0, bus.if_instr}, {24'd0, d});
        chk({tag, "_addr"},  {28'd0, bus.if_instr_addr}, {28'd0, a});
        chk({tag, "_valid"}, {31'd0, bus.if_instr_valid}, {31'd0, v});
    endtask

    task automatic chk_jmp(input string tag, input logic e, input logic [3:0] t);
        chk({tag, "_jmp_enb"}, {31'd0, bus.if_jmp_enb}, {31'd0, e});
        if (e) chk({tag, "_jmp_target"}, {28'd0, bus.if_jmp_target}, {28'd0, t});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.if_start     = 1'b0;
        bus.if_zero      = 1'b0;
        bus.if_prog_we   = 1'b0;
        bus.if_prog_addr = '0;
        bus.if_prog_data = '0;
        #1;
        chk("rst_valid",  {31'd0, bus.if_instr_valid}, 32'd0);
        chk("rst_halted", {31'd0, bus.if_halted}, 32'd0);
        chk_jmp("rst", 1'b1, 4'd0);
        chk("rst_instr",  {24'd0, bus.if_instr}, 32'd0);

        tick();
        for (int i = 0; i < 16; i++) prog(4'(i), 8'h00);
        prog(4'd0, 8'h11);
        prog(4'd1, 8'h22);
        prog(4'd2, 8'h33);
        prog(4'd3, 8'h44);
        rst = 1'b0;
        tick();
        chk_jmp("idle", 1'b1, 4'd0);
        chk("idle_valid", {31'd0, bus.if_instr_valid}, 32'd0);

        // Sequential fetch
        bus.if_start = 1'b1;
        tick();
        bus.if_start = 1'b0;
        chk("run_first_bubble", {31'd0, bus.if_instr_valid}, 32'd0);
        tick(); chk_ir("seq0", 8'h11, 4'd0, 1'b1);
        tick(); chk_ir("seq1", 8'h22, 4'd1, 1'b1);
        tick(); chk_ir("seq2", 8'h33, 4'd2, 1'b1);
        tick(); chk_ir("seq3", 8'h44, 4'd3, 1'b1);
`ifdef IFETCH_PERF_EN
        chk("perf_cnt3", {24'd0, retired_cnt}, 32'd3);
`endif

        // Unconditional jump
        prog(4'd2, 8'hA8);
        prog(4'd3, 8'h55);
        prog(4'd8, 8'h77);
        begin_run();
        tick(); tick();
        tick(); chk_ir("jmp", 8'hA8, 4'd2, 1'b1); chk_jmp("jmp", 1'b1, 4'd8);
        tick(); chk_ir("jmp_squash", 8'h55, 4'd3, 1'b0); chk_jmp("jmp_squash", 1'b0, 4'd0);
        tick(); chk_ir("jmp_dest", 8'h77, 4'd8, 1'b1);

        // JZ not taken
        prog(4'd2, 8'hB8);
        bus.if_zero = 1'b0;
        begin_run();
        tick(); tick();
        tick(); chk_ir("jz_nt", 8'hB8, 4'd2, 1'b1); chk_jmp("jz_nt", 1'b0, 4'd0);
        tick(); chk_ir("jz_nt_next", 8'h55, 4'd3, 1'b1);

        // JZ taken
        bus.if_zero = 1'b1;
        begin_run();
        tick(); tick();
        tick(); chk_ir("jz_t", 8'hB8, 4'd2, 1'b1); chk_jmp("jz_t", 1'b1, 4'd8);
        tick(); chk("jz_t_squash", {31'd0, bus.if_instr_valid}, 32'd0);
        tick(); chk_ir("jz_t_dest", 8'h77, 4'd8, 1'b1);
        bus.if_zero = 1'b0;

        // Halt
        prog(4'd2, 8'h33);
        prog(4'd3, 8'h44);
        prog(4'd5, 8'hF0);
        begin_run();
        for (int i = 0; i < 6; i++) tick();
        chk_ir("hlt", 8'hF0, 4'd5, 1'b1);
        chk_jmp("hlt", 1'b1, 4'd5);
        chk("hlt_not_yet", {31'd0, bus.if_halted}, 32'd0);
        tick();
        chk("halted", {31'd0, bus.if_halted}, 32'd1);
        chk("halted_valid", {31'd0, bus.if_instr_valid}, 32'd0);
        chk_jmp("halted", 1'b1, 4'd5);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("halted_pc", {28'd0, pc}, 32'd5);
        end
        bus.if_start = 1'b1;
        tick();
        chk("restart_idle_halted", {31'd0, bus.if_halted}, 32'd0);
        chk_jmp("restart_idle", 1'b1, 4'd0);
        tick();
        bus.if_start = 1'b0;
        chk("restart_run_pc", {28'd0, pc}, 32'd0);
        tick(); chk_ir("restart0", 8'h11, 4'd0, 1'b1);

        // Wrap from 15 to 0
        prog(4'd5, 8'h00);
        prog(4'd15, 8'h99);
        begin_run();
        for (int i = 0; i < 16; i++) tick();
        chk_ir("wrap15", 8'h99, 4'd15, 1'b1);
        tick(); chk_ir("wrap0", 8'h11, 4'd0, 1'b1);
        tick();

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid",  {31'd0, bus.if_instr_valid}, 32'd0);
        chk("async_halted", {31'd0, bus.if_halted}, 32'd0);
        chk_jmp("async", 1'b1, 4'd0);
`ifdef IFETCH_PERF_EN
        chk("async_perf", {24'd0, retired_cnt}, 32'd0);
`endif
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
